// File: rtl/uart_loopback_ctrl.sv
// uart_loopback_ctrl: moves bytes from the uart receive FIFO to the transmit
// FIFO through a selectable transform, in single, burst, auto or pause mode.
// Also exposes status, byte counters and the last raw byte for display logic.
// Optional build macro UART_LOOPBACK_CHECKSUM_EN adds a running XOR checksum
// of every pushed byte on output port chksum.
module uart_loopback_ctrl #(
  parameter int DBIT   = 8,
  parameter int OFFSET = 1,
  parameter int BURST  = 4,
  parameter int BW     = 4,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_tick,
  input  logic [1:0]       mode,
  input  logic [1:0]       xform,
  input  logic             rx_empty,
  input  logic [DBIT-1:0]  r_data,
  input  logic             tx_full,
  output logic             rd_uart,
  output logic             wr_uart,
  output logic [DBIT-1:0]  w_data,
  output logic [DBIT-1:0]  last_rx,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] tx_count,
  output logic             busy,
  output logic             tx_stall,
  output logic             drop
`ifdef UART_LOOPBACK_CHECKSUM_EN
  ,
  output logic [DBIT-1:0]  chksum
`endif
);

  localparam logic [1:0] M_SINGLE = 2'b00;
  localparam logic [1:0] M_BURST  = 2'b01;
  localparam logic [1:0] M_AUTO   = 2'b10;
  localparam logic [1:0] M_PAUSE  = 2'b11;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t           state_q, state_d;
  logic             pending_q, pending_d;
  logic [BW-1:0]    burst_q, burst_d;
  logic [1:0]       mode_q, mode_d;
  logic             drop_q, drop_d;
  logic [DBIT-1:0]  w_data_q;
  logic [DBIT-1:0]  last_rx_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic             mode_chg;
  logic             go;

  // ASCII case swap: only letters flip bit 5; non-8-bit words pass through.
  function automatic logic [DBIT-1:0] case_swap(input logic [DBIT-1:0] d);
    logic [7:0]      b;
    logic [DBIT-1:0] r;
    r = d;
    b = 8'(d);
    if (DBIT == 8) begin
      if ((b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A))
        r = DBIT'(b ^ 8'h20);
    end
    return r;
  endfunction

  // Byte transform selected by xform; the add wraps modulo 2^DBIT.
  function automatic logic [DBIT-1:0] xform_f(input logic [DBIT-1:0] d,
                                              input logic [1:0]      sel);
    logic [DBIT-1:0] r;
    case (sel)
      2'b01:   r = d + DBIT'(OFFSET);
      2'b10:   r = ~d;
      2'b11:   r = case_swap(d);
      default: r = d;
    endcase
    return r;
  endfunction

  // Mode is only sampled in IDLE; a differing input there is a mode change,
  // which spends that cycle clearing pending work instead of transferring.
  assign mode_chg = (state_q == IDLE) && (mode != mode_q);
  assign go = !mode_chg &&
              (((mode_q == M_SINGLE) && pending_q) ||
               ((mode_q == M_BURST) && (burst_q != '0)) ||
               (mode_q == M_AUTO));

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: pop moves to SEND, a successful push returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rd_uart)  state_d = SEND;
      SEND:    if (!tx_full) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: pop strobe in IDLE, push strobe or stall in SEND.
  always_comb begin
    rd_uart  = 1'b0;
    wr_uart  = 1'b0;
    tx_stall = 1'b0;
    case (state_q)
      IDLE: rd_uart = go && !rx_empty;
      SEND: begin
        wr_uart  = !tx_full;
        tx_stall = tx_full;
      end
      default: ;
    endcase
  end

  // Trigger bookkeeping: pending (single), burst_left (burst), drop, mode.
  always_comb begin
    pending_d = pending_q;
    burst_d   = burst_q;
    mode_d    = mode_q;
    drop_d    = drop_q;
    if (mode_chg) begin
      mode_d    = mode;
      pending_d = 1'b0;
      burst_d   = '0;
    end else begin
      if (rd_uart) begin
        if (mode_q == M_SINGLE) pending_d = 1'b0;
        if (mode_q == M_BURST)  burst_d   = burst_q - BW'(1);
      end else if ((state_q == IDLE) && (mode_q == M_BURST) &&
                   (burst_q != '0) && rx_empty) begin
        // Burst aborts rather than waiting for more receive data.
        burst_d = '0;
      end
      if (btn_tick) begin
        case (mode_q)
          M_SINGLE: begin
            // A trigger with nothing to send is dropped, not remembered.
            if (rx_empty)        drop_d    = 1'b1;
            else if (!pending_q) pending_d = 1'b1;
          end
          M_BURST: begin
            burst_d = BW'(BURST);
            if (rx_empty) drop_d = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= 1'b0;
      burst_q   <= '0;
      mode_q    <= M_SINGLE;
      drop_q    <= 1'b0;
    end else begin
      pending_q <= pending_d;
      burst_q   <= burst_d;
      mode_q    <= mode_d;
      drop_q    <= drop_d;
    end
  end

  // Datapath: capture and transform on pop, count pops and pushes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_data_q  <= '0;
      last_rx_q <= '0;
      rx_cnt_q  <= '0;
      tx_cnt_q  <= '0;
    end else begin
      if (rd_uart) begin
        last_rx_q <= r_data;
        w_data_q  <= xform_f(r_data, xform);
        rx_cnt_q  <= rx_cnt_q + CNT_W'(1);
      end
      if (wr_uart) tx_cnt_q <= tx_cnt_q + CNT_W'(1);
    end
  end

`ifdef UART_LOOPBACK_CHECKSUM_EN
  logic [DBIT-1:0] chk_q;

  // Running XOR of pushed bytes; a trigger while the mode input is pause clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                             chk_q <= '0;
    else if (btn_tick && (mode == M_PAUSE)) chk_q <= '0;
    else if (wr_uart)                       chk_q <= chk_q ^ w_data_q;
  end

  assign chksum = chk_q;
`endif

  assign w_data   = w_data_q;
  assign last_rx  = last_rx_q;
  assign rx_count = rx_cnt_q;
  assign tx_count = tx_cnt_q;
  assign drop     = drop_q;
  assign busy     = (state_q == SEND) || pending_q || (burst_q != '0);

endmodule

// File: tb/tb_uart_loopback_ctrl.sv
// Bench for uart_loopback_ctrl: behavioural receive FIFO, expected-byte
// scoreboard checked on every push, transform vector table plus sequences.
module tb_uart_loopback_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_tick;
  logic [1:0]  mode;
  logic [1:0]  xform;
  logic        rx_empty;
  logic [7:0]  r_data;
  logic        tx_full;
  logic        rd_uart;
  logic        wr_uart;
  logic [7:0]  w_data;
  logic [7:0]  last_rx;
  logic [15:0] rx_count;
  logic [15:0] tx_count;
  logic        busy;
  logic        tx_stall;
  logic        drop;
`ifdef UART_LOOPBACK_CHECKSUM_EN
  logic [7:0]  chksum;
`endif

  always #5 clk = ~clk;

  uart_loopback_ctrl #(
    .DBIT(8), .OFFSET(1), .BURST(4), .BW(4), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .btn_tick(btn_tick), .mode(mode),
    .xform(xform), .rx_empty(rx_empty), .r_data(r_data), .tx_full(tx_full),
    .rd_uart(rd_uart), .wr_uart(wr_uart), .w_data(w_data),
    .last_rx(last_rx), .rx_count(rx_count), .tx_count(tx_count),
    .busy(busy), .tx_stall(tx_stall), .drop(drop)
`ifdef UART_LOOPBACK_CHECKSUM_EN
    , .chksum(chksum)
`endif
  );

  typedef struct packed {
    logic [1:0] xf;
    logic [7:0] din;
    logic [7:0] dout;
  } vec_t;

  vec_t       vtab [14];
  logic [7:0] rxq [$];
  logic [7:0] sb  [$];
  int ncmp = 0, nfail = 0;
  int npop = 0, npush = 0, nstall = 0, cycnum = 0;
  int last_pop_cyc = 0, last_push_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock cycle: present FIFO head, sample mid-cycle, model FIFO pop and
  // score pushes, then step past the rising edge.
  task automatic cyc();
    logic rd_s, wr_s, st_s;
    logic [7:0] wd, ex;
    rx_empty = (rxq.size() == 0);
    r_data   = rx_empty ? 8'h00 : rxq[0];
    @(negedge clk);
    cycnum++;
    rd_s = rd_uart; wr_s = wr_uart; st_s = tx_stall; wd = w_data;
    if (rd_s && wr_s) begin
      ncmp++; nfail++;
      $display("FAIL strobe_overlap: got rd=1 wr=1, expected at most one");
    end
    if (rd_s) begin
      npop++; last_pop_cyc = cycnum;
      if (rxq.size() != 0) void'(rxq.pop_front());
    end
    if (wr_s) begin
      npush++; last_push_cyc = cycnum;
      if (sb.size() == 0) begin
        ncmp++; nfail++;
        $display("FAIL unexpected_push: got w_data=0x%0h, expected no push", wd);
      end else begin
        ex = sb.pop_front();
        chk("w_data", {24'd0, wd}, {24'd0, ex});
      end
    end
    if (st_s) nstall++;
    @(posedge clk);
    #1;
    btn_tick = 1'b0;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic run_until_push(input int target, input int budget);
    int n;
    n = 0;
    while (npush < target && n < budget) begin
      cyc();
      n++;
    end
    if (npush < target) begin
      ncmp++; nfail++;
      $display("FAIL push_timeout: got %0d pushes, expected %0d", npush, target);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, q0, s0, k, n;
    vtab[0]  = '{2'b00, 8'h5A, 8'h5A};
    vtab[1]  = '{2'b01, 8'hFF, 8'h00};
    vtab[2]  = '{2'b01, 8'h7F, 8'h80};
    vtab[3]  = '{2'b10, 8'h0F, 8'hF0};
    vtab[4]  = '{2'b10, 8'h00, 8'hFF};
    vtab[5]  = '{2'b11, 8'h41, 8'h61};
    vtab[6]  = '{2'b11, 8'h5A, 8'h7A};
    vtab[7]  = '{2'b11, 8'h61, 8'h41};
    vtab[8]  = '{2'b11, 8'h7A, 8'h5A};
    vtab[9]  = '{2'b11, 8'h40, 8'h40};
    vtab[10] = '{2'b11, 8'h5B, 8'h5B};
    vtab[11] = '{2'b11, 8'h60, 8'h60};
    vtab[12] = '{2'b11, 8'h7B, 8'h7B};
    vtab[13] = '{2'b11, 8'h30, 8'h30};

    reset = 1'b1; btn_tick = 1'b0; mode = 2'b00; xform = 2'b00;
    tx_full = 1'b0; rx_empty = 1'b1; r_data = 8'h00;
    #1 reset = 1'b0;

    // Reset held with data waiting and trigger pulsing.
    rxq.push_back(8'h55);
    for (int i = 0; i < 4; i++) begin
      btn_tick = (i % 2 == 0);
      cyc();
    end
    chk("reset_pops", npop, 0);
    chk("reset_pushes", npush, 0);
    chk("reset_w_data", {24'd0, w_data}, 0);
    chk("reset_last_rx", {24'd0, last_rx}, 0);
    chk("reset_rx_count", {16'd0, rx_count}, 0);
    chk("reset_tx_count", {16'd0, tx_count}, 0);
    chk("reset_busy", {31'd0, busy}, 0);
    chk("reset_tx_stall", {31'd0, tx_stall}, 0);
    chk("reset_drop", {31'd0, drop}, 0);
    rxq.delete();
    reset = 1'b1;
    run_cycles(2);

    // Single mode, add transform: 0x41 -> 0x42, then 0xFF -> 0x00.
    xform = 2'b01;
    rxq.push_back(8'h41); sb.push_back(8'h42);
    btn_tick = 1'b1; cyc();
    run_until_push(1, 10);
    chk("single_latency", last_push_cyc - last_pop_cyc, 1);
    chk("single_last_rx", {24'd0, last_rx}, 32'h41);
    chk("single_rx_count", {16'd0, rx_count}, 1);
    chk("single_tx_count", {16'd0, tx_count}, 1);
    rxq.push_back(8'hFF); sb.push_back(8'h00);
    btn_tick = 1'b1; cyc();
    run_until_push(2, 10);
    chk("single2_last_rx", {24'd0, last_rx}, 32'hFF);
    chk("single2_tx_count", {16'd0, tx_count}, 2);

    // Transform table in auto mode.
    mode = 2'b10; run_cycles(2);
    for (int i = 0; i < 14; i++) begin
      xform = vtab[i].xf;
      rxq.push_back(vtab[i].din);
      sb.push_back(vtab[i].dout);
      run_until_push(npush + 1, 8);
    end
    chk("table_rx_count", {16'd0, rx_count}, 16);
    chk("table_tx_count", {16'd0, tx_count}, 16);

    // Burst of 4 with 6 queued, then burst with only 2 left (aborts).
    mode = 2'b01; xform = 2'b00; run_cycles(2);
    for (int b = 1; b <= 6; b++) rxq.push_back(8'(b));
    for (int b = 1; b <= 4; b++) sb.push_back(8'(b));
    p0 = npop; q0 = npush;
    btn_tick = 1'b1; cyc(); k = cycnum;
    run_cycles(12);
    chk("burst_pops", npop - p0, 4);
    chk("burst_pushes", npush - q0, 4);
    chk("burst_remaining", rxq.size(), 2);
    chk("burst_last_push_cyc", last_push_cyc - k, 8);
    chk("burst_busy", {31'd0, busy}, 0);
    sb.push_back(8'h05); sb.push_back(8'h06);
    p0 = npop; q0 = npush;
    btn_tick = 1'b1; cyc();
    run_cycles(10);
    chk("burst2_pops", npop - p0, 2);
    chk("burst2_pushes", npush - q0, 2);
    chk("burst2_remaining", rxq.size(), 0);
    chk("burst2_busy", {31'd0, busy}, 0);

    // Back-pressure in auto mode with case swap.
    mode = 2'b10; xform = 2'b11; run_cycles(2);
    tx_full = 1'b1;
    rxq.push_back(8'h61); rxq.push_back(8'h62);
    sb.push_back(8'h41);  sb.push_back(8'h42);
    p0 = npop; q0 = npush; n = 0;
    while (npop == p0 && n < 6) begin cyc(); n++; end
    chk("bp_first_pop", npop - p0, 1);
    s0 = nstall;
    run_cycles(5);
    chk("bp_stall_cycles", nstall - s0, 5);
    chk("bp_no_second_pop", npop - p0, 1);
    chk("bp_no_push", npush - q0, 0);
    chk("bp_tx_stall_now", {31'd0, tx_stall}, 1);
    tx_full = 1'b0;
    run_until_push(q0 + 1, 3);
    chk("bp_pop_before_push", npop - p0, 1);
    run_until_push(q0 + 2, 6);
    chk("bp_counts_equal", {16'd0, rx_count}, {16'd0, tx_count});

    // Trigger with empty receive FIFO: drop, and no late transfer.
    mode = 2'b00; run_cycles(2);
    chk("drop_before", {31'd0, drop}, 0);
    p0 = npop;
    btn_tick = 1'b1; cyc();
    chk("drop_set", {31'd0, drop}, 1);
    chk("drop_not_busy", {31'd0, busy}, 0);
    run_cycles(3);
    rxq.push_back(8'hAA);
    run_cycles(6);
    chk("drop_no_transfer", npop - p0, 0);
    chk("drop_sticky", {31'd0, drop}, 1);
    rxq.delete();

`ifdef UART_LOOPBACK_CHECKSUM_EN
    // Checksum: clear, accumulate 0x12 ^ 0x34, clear again.
    mode = 2'b11; run_cycles(2);
    btn_tick = 1'b1; cyc();
    chk("chksum_clear1", {24'd0, chksum}, 0);
    mode = 2'b10; xform = 2'b00; run_cycles(2);
    rxq.push_back(8'h12); rxq.push_back(8'h34);
    sb.push_back(8'h12);  sb.push_back(8'h34);
    run_until_push(npush + 2, 10);
    chk("chksum_value", {24'd0, chksum}, 32'h26);
    mode = 2'b11; run_cycles(2);
    btn_tick = 1'b1; cyc();
    chk("chksum_clear2", {24'd0, chksum}, 0);
`endif

    chk("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
